// File: rtl/mem_access_unit_if.sv
// ---------------------------------------------------------------------------
// mem_access_unit_if
// Data-memory bus between the load/store unit (master) and memory (slave).
// Simple req/ack protocol with per-byte-lane enables.
//   o_bus_req    master->slave  request, held until ack or abort
//   o_bus_we     master->slave  1 = write
//   o_bus_addr   master->slave  word-aligned address
//   o_bus_be     master->slave  byte enables, bit n = lane n (bits 8n+7:8n)
//   o_bus_wdata  master->slave  lane-replicated write data
//   i_bus_ack    slave->master  completion, read data valid same cycle
//   i_bus_rdata  slave->master  read word
// Signal names are from the unit's point of view.
// ---------------------------------------------------------------------------
interface mem_access_unit_if;
   logic        o_bus_req;
   logic        o_bus_we;
   logic [31:0] o_bus_addr;
   logic [3:0]  o_bus_be;
   logic [31:0] o_bus_wdata;
   logic        i_bus_ack;
   logic [31:0] i_bus_rdata;

   modport master (
      output o_bus_req, o_bus_we, o_bus_addr, o_bus_be, o_bus_wdata,
      input  i_bus_ack, i_bus_rdata
   );

   modport slave (
      input  o_bus_req, o_bus_we, o_bus_addr, o_bus_be, o_bus_wdata,
      output i_bus_ack, i_bus_rdata
   );
endinterface

// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
// MIPS load/store stage: one data-memory transaction per request.
// Takes the ALU result as effective address and rt as store data, drives a
// req/ack bus with byte enables, returns sign/zero-extended load data, and
// flags misaligned accesses and bus timeouts.
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_req               start access (sampled in IDLE only)
//   i_we                1 = store, 0 = load
//   i_size              00 byte, 01 half, 10 word, 11 reserved
//   i_unsigned          loads: 1 = zero-extend, 0 = sign-extend
//   i_addr, i_wdata     effective address, right-aligned store data
//   o_busy              high in BUS and RESP
//   o_done              one-cycle completion pulse
//   o_rdata             extended load data, held until next load completes
//   o_misalign          with o_done: misaligned address or reserved size
//   o_timeout           with o_done: no ack within TIMEOUT_CYCLES
//   bus                 memory bus (master modport)
// ---------------------------------------------------------------------------

// One byte lane of the store path: enable bit and write byte for lane LANE.
// The three byte sources are pre-sliced by the parent so each lane only sees
// the bits it can actually select.
module mau_lane #(
   parameter int LANE = 0
) (
   input  logic [1:0] i_lane,
   input  logic [1:0] i_size,
   input  logic [7:0] i_byte_src,
   input  logic [7:0] i_half_src,
   input  logic [7:0] i_word_src,
   output logic       o_be,
   output logic [7:0] o_wdata
);
   localparam logic [1:0] LP_IDX = 2'(LANE);

   always_comb begin
      o_be    = 1'b0;
      o_wdata = 8'h00;
      case (i_size)
         2'b00: begin
            o_be    = (i_lane == LP_IDX);
            o_wdata = i_byte_src;
         end
         2'b01: begin
            o_be    = (i_lane[1] == LP_IDX[1]);
            o_wdata = i_half_src;
         end
         2'b10: begin
            o_be    = 1'b1;
            o_wdata = i_word_src;
         end
         default: ;
      endcase
   end
endmodule

module mem_access_unit #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic                      i_req,
   input  logic                      i_we,
   input  logic [1:0]                i_size,
   input  logic                      i_unsigned,
   input  logic [31:0]               i_addr,
   input  logic [31:0]               i_wdata,
   output logic                      o_busy,
   output logic                      o_done,
   output logic [31:0]               o_rdata,
   output logic                      o_misalign,
   output logic                      o_timeout,
   mem_access_unit_if.master         bus
);
   localparam int          NUM_LANES = 4;
   localparam logic [15:0] LP_LAST   = 16'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;

   // Fields needed to shape load data once the ack arrives.
   typedef struct packed {
      logic [1:0] lane;
      logic [1:0] size;
      logic       uns;
   } req_t;

   state_t      r_state;
   req_t        r_req;
   logic [15:0] r_cnt;
   logic        r_busy;
   logic        r_done;
   logic [31:0] r_rdata;
   logic        r_misalign;
   logic        r_timeout;
   logic        r_bus_req;
   logic        r_bus_we;
   logic [31:0] r_bus_addr;
   logic [3:0]  r_bus_be;
   logic [31:0] r_bus_wdata;

   logic                          w_misalign;
   logic [NUM_LANES-1:0]          w_be;
   logic [NUM_LANES-1:0][7:0]     w_wdata;

   // Reserved size is reported as misaligned so it never reaches the bus.
   assign w_misalign = (i_size == 2'b11) ||
                       (i_size == 2'b01 && i_addr[0]) ||
                       (i_size == 2'b10 && (i_addr[1:0] != 2'b00));

   for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
      mau_lane #(.LANE(g)) u_lane (
         .i_lane     (i_addr[1:0]),
         .i_size     (i_size),
         .i_byte_src (i_wdata[7:0]),
         .i_half_src (i_wdata[8*(g%2) +: 8]),
         .i_word_src (i_wdata[8*g +: 8]),
         .o_be       (w_be[g]),
         .o_wdata    (w_wdata[g])
      );
   end

   function automatic logic [31:0] f_extract(input logic [31:0] rd, input req_t rq);
      logic [7:0]  b;
      logic [15:0] h;
      b = rd[{rq.lane, 3'b000} +: 8];
      h = rd[{rq.lane[1], 4'b0000} +: 16];
      case (rq.size)
         2'b00:   return rq.uns ? {24'h0, b} : {{24{b[7]}}, b};
         2'b01:   return rq.uns ? {16'h0, h} : {{16{h[15]}}, h};
         default: return rd;
      endcase
   endfunction

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= S_IDLE;
         r_req       <= '0;
         r_cnt       <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_rdata     <= '0;
         r_misalign  <= 1'b0;
         r_timeout   <= 1'b0;
         r_bus_req   <= 1'b0;
         r_bus_we    <= 1'b0;
         r_bus_addr  <= '0;
         r_bus_be    <= '0;
         r_bus_wdata <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_req) begin
                  r_req  <= '{lane: i_addr[1:0], size: i_size, uns: i_unsigned};
                  r_busy <= 1'b1;
                  if (w_misalign) begin
                     r_state    <= S_RESP;
                     r_done     <= 1'b1;
                     r_misalign <= 1'b1;
                  end else begin
                     r_state     <= S_BUS;
                     r_cnt       <= '0;
                     r_bus_req   <= 1'b1;
                     r_bus_we    <= i_we;
                     r_bus_addr  <= {i_addr[31:2], 2'b00};
                     r_bus_be    <= w_be;
                     r_bus_wdata <= w_wdata;
                  end
               end
            end
            S_BUS: begin
               // Ack wins over the final count.
               if (bus.i_bus_ack || r_cnt == LP_LAST) begin
                  if (bus.i_bus_ack) begin
                     if (!r_bus_we) r_rdata <= f_extract(bus.i_bus_rdata, r_req);
                  end else begin
                     r_timeout <= 1'b1;
                  end
                  r_state     <= S_RESP;
                  r_done      <= 1'b1;
                  r_bus_req   <= 1'b0;
                  r_bus_we    <= 1'b0;
                  r_bus_addr  <= '0;
                  r_bus_be    <= '0;
                  r_bus_wdata <= '0;
               end else begin
                  r_cnt <= r_cnt + 16'd1;
               end
            end
            S_RESP: begin
               r_state    <= S_IDLE;
               r_busy     <= 1'b0;
               r_done     <= 1'b0;
               r_misalign <= 1'b0;
               r_timeout  <= 1'b0;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_busy          = r_busy;
   assign o_done          = r_done;
   assign o_rdata         = r_rdata;
   assign o_misalign      = r_misalign;
   assign o_timeout       = r_timeout;
   assign bus.o_bus_req   = r_bus_req;
   assign bus.o_bus_we    = r_bus_we;
   assign bus.o_bus_addr  = r_bus_addr;
   assign bus.o_bus_be    = r_bus_be;
   assign bus.o_bus_wdata = r_bus_wdata;
endmodule
